// File: rtl/ro_burst_responder.sv
// ro_burst_responder: responder end of the RO-stage burst-read interface.
// Takes one burst request, fetches each 64-byte line that covers the burst
// (never more than one line read in flight), and returns every 32-bit word
// as its own response tagged with its position in the burst.
module ro_burst_responder #(
   parameter int unsigned TILE_ID         = 0,
   parameter int unsigned LINE_BYTES      = 64,
   parameter type         task_t          = logic [63:0],
   parameter type         subtype_t       = logic [3:0],
   parameter type         cq_slice_slot_t = logic [5:0]
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_addr,
   input  logic [7:0]                req_len,
   input  logic [2:0]                req_size,
   input  task_t                     req_task,
   input  subtype_t                  req_subtype,
   input  cq_slice_slot_t            req_cq_slot,
   input  logic                      req_mark_last,
   output logic                      mem_arvalid,
   input  logic                      mem_arready,
   output logic [31:0]               mem_araddr,
   input  logic                      mem_rvalid,
   output logic                      mem_rready,
   input  logic [8*LINE_BYTES-1:0]   mem_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output task_t                     out_task,
   output logic [31:0]               out_data,
   output logic [7:0]                out_word_id,
   output subtype_t                  out_subtype,
   output cq_slice_slot_t            out_cq_slot,
   output logic                      out_last,
   output logic                      err_size
);

   localparam int unsigned WORDS = LINE_BYTES / 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

   state_t         state_q, state_d;
   logic [25:0]    line_q, line_d;
   logic [3:0]     off_q, off_d;
   logic [7:0]     wid_q, wid_d;
   logic [8:0]     left_q, left_d;
   logic [31:0]    line_buf_q [WORDS];
   logic [31:0]    line_buf_d [WORDS];
   task_t          task_q, task_d;
   subtype_t       sub_q, sub_d;
   cq_slice_slot_t slot_q, slot_d;
   logic           mark_q, mark_d;
   logic           err_q, err_d;
   logic           live;
   logic           unused_ok;

   // Word-address low bits and the debug tile index do not affect behaviour.
   assign unused_ok = ^{req_addr[1:0], (TILE_ID == 32'd0)};

   // While reset is asserted every output reads as zero.
   assign live = !rst;

   // Next-state and datapath updates for the accept/issue/wait/emit sequence
   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      off_d      = off_q;
      wid_d      = wid_q;
      left_d     = left_q;
      line_buf_d = line_buf_q;
      task_d     = task_q;
      sub_d      = sub_q;
      slot_d     = slot_q;
      mark_d     = mark_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               task_d = req_task;
               sub_d  = req_subtype;
               slot_d = req_cq_slot;
               mark_d = req_mark_last;
               line_d = req_addr[31:6];
               off_d  = req_addr[5:2];
               wid_d  = '0;
               left_d = {1'b0, req_len} + 9'd1;
               // Odd sizes are flagged but still served as 32-bit beats.
               if (req_size != 3'd2) begin
                  err_d = 1'b1;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_arready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               for (int unsigned k = 0; k < WORDS; k++) begin
                  line_buf_d[k] = mem_rdata[32*k +: 32];
               end
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               wid_d  = wid_q + 8'd1;
               left_d = left_q - 9'd1;
               off_d  = off_q + 4'd1;
               if (left_q == 9'd1) begin
                  state_d = IDLE;
               end else if (off_q == 4'hF) begin
                  line_d  = line_q + 26'd1;
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and request-context registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         line_q  <= '0;
         off_q   <= '0;
         wid_q   <= '0;
         left_q  <= '0;
         task_q  <= '0;
         sub_q   <= '0;
         slot_q  <= '0;
         mark_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         off_q   <= off_d;
         wid_q   <= wid_d;
         left_q  <= left_d;
         task_q  <= task_d;
         sub_q   <= sub_d;
         slot_q  <= slot_d;
         mark_q  <= mark_d;
         err_q   <= err_d;
      end
   end

   // Line buffer holds fetched data only; its contents after reset are unused.
   always_ff @(posedge clk) begin
      line_buf_q <= line_buf_d;
   end

   // Outputs decode purely from registered state, forced low during reset
   always_comb begin
      req_ready   = live && (state_q == IDLE);
      mem_arvalid = live && (state_q == ISSUE);
      mem_araddr  = live ? {line_q, 6'b0} : '0;
      mem_rready  = live && (state_q == WAIT);
      out_valid   = live && (state_q == EMIT);
      out_task    = live ? task_q : '0;
      out_data    = live ? line_buf_q[off_q] : '0;
      out_word_id = live ? wid_q : '0;
      out_subtype = live ? sub_q : '0;
      out_cq_slot = live ? slot_q : '0;
      out_last    = live && mark_q && (left_q == 9'd1);
      err_size    = live && err_q;
   end

endmodule

// File: doc/ro_burst_responder.md
# ro_burst_responder

Responder end of the RO-stage burst-read interface. Accepts one read request per task (start address, beat count, template task), fetches the covering 64-byte lines from the tile's memory port, and returns each 32-bit word as its own response task tagged with a word id. It sits between an app RO stage's `arvalid/araddr/arlen/resp_task` outputs and its `in_data/in_word_id` inputs, so app logic such as the silo enqueuer only sees one word per re-entered task.

## Interface
Parameters:
- `TILE_ID`, 0, tile index; debug only.
- `LINE_BYTES`, 64, memory line size; fixed at 64 (16 words per line).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both high.
- `req_addr` in 32: byte address of word 0; bits [1:0] ignored.
- `req_len` in 8: beats minus one (`arlen`); words = `req_len`+1.
- `req_size` in 3: must be 2.
- `req_task` in task_t: template for response tasks.
- `req_subtype` in subtype_t: subtype stamped on responses.
- `req_cq_slot` in cq_slice_slot_t: slot stamped on responses.
- `req_mark_last` in 1: flag the final response.
- `mem_arvalid`, `mem_arready` out/in 1: line read request handshake.
- `mem_araddr` out 32: line-aligned address.
- `mem_rvalid`, `mem_rready` in/out 1: line data handshake.
- `mem_rdata` in 512: line data; word k at bits [32k+31:32k].
- `out_valid`, `out_ready` out/in 1: response handshake.
- `out_task` out task_t: copy of `req_task`.
- `out_data` out 32: word.
- `out_word_id` out 8: 0..`req_len`.
- `out_subtype` out subtype_t; `out_cq_slot` out cq_slice_slot_t.
- `out_last` out 1: high only on the word with id `req_len`, and only if `req_mark_last` is set.
- `err_size` out 1: sticky; set when a request is accepted with `req_size`≠2.

## Operation
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE: `req_ready`=1. On accept, register task, subtype, slot, mark_last. Set `line_addr`={addr[31:6],6'b0}, `off`=addr[5:2], `wid`=0, `left`=len+1 (9 bits). If size≠2, set `err_size`, then process as size 2. Go to ISSUE.
- ISSUE: `mem_arvalid`=1, `mem_araddr`=`line_addr`. On `mem_arready`, go to WAIT.
- WAIT: `mem_rready`=1. On `mem_rvalid`, latch `mem_rdata` into the line buffer and go to EMIT.
- EMIT: `out_valid`=1, `out_data`=buf[32·off+:32], `out_word_id`=`wid`. On `out_ready`: `wid`++, `left`--, `off`++ (4-bit wrap).
  - If `left` was 1, go to IDLE.
  - Else if `off` was 15, set `line_addr`+=64 (32-bit wrap) and go to ISSUE.
  - Else stay in EMIT.
- At most one outstanding line read at any time.
- Reset: state to IDLE; counters cleared; buffer contents don't-care. While `rst` is high, all outputs are 0 (`req_ready`=0). `err_size` clears only on reset. The memory port shares `rst`; no stale response survives a reset.

## Timing
- Request accepted at cycle T → `mem_arvalid` at T+1.
- `mem_rvalid` accepted at cycle R → first `out_valid` at R+1.
- Within a line, one word per cycle while `out_ready`=1.
- Line crossing: `mem_arvalid` rises the cycle after offset-15 word is accepted.
- Last word accepted at cycle L → `req_ready`=1 at L+1. One-cycle bubble between requests.
- Payload stability: while `out_valid`=1 and `out_ready`=0, all `out_*` hold stable. While `mem_arvalid`=1 and `mem_arready`=0, `mem_araddr` holds stable.
- `req_len`=255 gives 256 words: `left` is 9 bits, `wid` reaches 255 without wrap.
- Reset high during any state → the next cycle is IDLE with all outputs 0.

## Test plan
- addr 0x1000, len 8, mark_last 1: one line read at 0x1000. Nine outputs, ids 0..8, data = line words 0..8. `out_last` high only on id 8.
- addr 0x1038, len 3: reads at 0x1000 then 0x1040. Outputs: words 14 and 15 of line A, then words 0 and 1 of line B, with ids 0..3.
- len 0, mark_last 0: single output, id 0, `out_last`=0. `req_ready` returns the cycle after acceptance.
- Backpressure: `out_ready` low for 5 cycles mid-burst and `mem_arready` low for 3 cycles. Payload and `mem_araddr` stay stable; no id skipped or duplicated.
- addr 0x0, len 255: exactly 16 line reads (0x0..0x3C0) and 256 outputs with ids 0..255 in order.
- Request with size 3: `err_size`=1 and the words are still returned. Then assert `rst` during EMIT: next cycle `out_valid`=0 and `err_size`=0. After `rst` falls, `req_ready`=1 and a fresh request completes normally.
